// File: rtl/regfile_wr_arbiter.sv
// rtl/regfile_wr_arbiter.sv - round-robin arbiter for the register bank write port
//
// Purpose: shares the single write port of the register bank between NREQ
// writeback sources. One requester is granted per cycle, round-robin from PTR.
// The accepted write is presented to the bank one cycle later as a registered
// one-hot enable plus data. Writes to register 0 (or to an address beyond NREG)
// are accepted but suppressed, and are counted in DROP_CNT.
//
// Ports:
//   CLK        rising-edge clock
//   RSTN       asynchronous active-low reset
//   FREEZE     pipeline stall, blocks new grants
//   REQ_VALID  per-requester request valid
//   REQ_ADDR   per-requester destination register, slice [i*AW +: AW]
//   REQ_DATA   per-requester write data, slice [i*DW +: DW]
//   REQ_READY  one-hot grant (combinational)
//   WR_EN      one-hot register enable to the bank (registered)
//   WR_DATA    write data to the bank (registered)
//   GRANT_ID   requester whose write is currently on WR_EN (registered)
//   BUSY       write stage holds a write
//   DROP_CNT   saturating count of suppressed writes
module regfile_wr_arbiter #(
  parameter int NREQ = 4,
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int DW   = 32,
  parameter int IDW  = 2
) (
  input  logic               CLK,
  input  logic               RSTN,
  input  logic               FREEZE,
  input  logic [NREQ-1:0]    REQ_VALID,
  input  logic [NREQ*AW-1:0] REQ_ADDR,
  input  logic [NREQ*DW-1:0] REQ_DATA,
  output logic [NREQ-1:0]    REQ_READY,
  output logic [NREG-1:0]    WR_EN,
  output logic [DW-1:0]      WR_DATA,
  output logic [IDW-1:0]     GRANT_ID,
  output logic               BUSY,
  output logic [7:0]         DROP_CNT
);

  localparam logic [0:0]      IDLE    = 1'b0;
  localparam logic [0:0]      WRITE   = 1'b1;
  localparam logic [NREG-1:0] EN_ONE  = {{(NREG-1){1'b0}}, 1'b1};
  localparam logic [NREQ-1:0] REQ_ONE = {{(NREQ-1){1'b0}}, 1'b1};

  logic           rst_sync;
  logic [0:0]     state;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] ptr_next;

  logic           found;
  logic [IDW-1:0] win;
  logic [AW-1:0]  win_addr;
  logic [DW-1:0]  win_data;
  logic           win_drop;
  logic           xfer;
  logic [IDW-1:0] idx_w;
  int             idx;
  int             nxt;

  logic [AW-1:0]  addr_a [NREQ];
  logic [DW-1:0]  data_a [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign addr_a[g] = REQ_ADDR[g*AW +: AW];
    assign data_a[g] = REQ_DATA[g*DW +: DW];
  end

  // Single-stage release synchroniser: grants open one edge after RSTN rises,
  // so the first transfer can land on the second rising edge.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) rst_sync <= 1'b0;
    else       rst_sync <= 1'b1;
  end

  // Rotating priority search starting at ptr, ascending with wrap.
  always_comb begin
    found    = 1'b0;
    win      = '0;
    win_addr = '0;
    win_data = '0;
    idx      = 0;
    idx_w    = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      idx_w = IDW'(idx);
      if (!found && REQ_VALID[idx_w]) begin
        found    = 1'b1;
        win      = idx_w;
        win_addr = addr_a[idx_w];
        win_data = data_a[idx_w];
      end
    end
  end

  always_comb begin
    xfer      = found && !FREEZE && rst_sync;
    REQ_READY = xfer ? (REQ_ONE << win) : '0;
    win_drop  = (win_addr == '0) || (int'(win_addr) >= NREG);
    nxt       = int'(win) + 1;
    if (nxt >= NREQ) nxt = 0;
    ptr_next  = IDW'(nxt);
  end

  // The enable is decoded before the flop so WR_EN leaves a register with no
  // logic after it and stays glitch-free for the bank's enable gating.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state    <= IDLE;
      ptr      <= '0;
      WR_EN    <= '0;
      WR_DATA  <= '0;
      GRANT_ID <= '0;
      DROP_CNT <= '0;
    end else if (xfer) begin
      state    <= WRITE;
      ptr      <= ptr_next;
      WR_DATA  <= win_data;
      GRANT_ID <= win;
      WR_EN    <= win_drop ? '0 : (EN_ONE << win_addr);
      if (win_drop && (DROP_CNT != 8'hFF)) DROP_CNT <= DROP_CNT + 8'd1;
    end else begin
      state <= IDLE;
      WR_EN <= '0;
    end
  end

  assign BUSY = (state == WRITE);

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// tb/tb_regfile_wr_arbiter.sv - scoreboard testbench for regfile_wr_arbiter
module tb_regfile_wr_arbiter;

  localparam int NREQ = 4;
  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int DW   = 32;
  localparam int IDW  = 2;

  logic              CLK = 1'b0;
  logic              RSTN = 1'b0;
  logic              FREEZE = 1'b0;
  logic [NREQ-1:0]   REQ_VALID = '0;
  logic [NREQ*AW-1:0] REQ_ADDR = '0;
  logic [NREQ*DW-1:0] REQ_DATA = '0;
  logic [NREQ-1:0]   REQ_READY;
  logic [NREG-1:0]   WR_EN;
  logic [DW-1:0]     WR_DATA;
  logic [IDW-1:0]    GRANT_ID;
  logic              BUSY;
  logic [7:0]        DROP_CNT;

  regfile_wr_arbiter #(
    .NREQ(NREQ), .NREG(NREG), .AW(AW), .DW(DW), .IDW(IDW)
  ) dut (
    .CLK(CLK), .RSTN(RSTN), .FREEZE(FREEZE),
    .REQ_VALID(REQ_VALID), .REQ_ADDR(REQ_ADDR), .REQ_DATA(REQ_DATA),
    .REQ_READY(REQ_READY), .WR_EN(WR_EN), .WR_DATA(WR_DATA),
    .GRANT_ID(GRANT_ID), .BUSY(BUSY), .DROP_CNT(DROP_CNT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] en;
    logic [31:0] data;
    logic [1:0]  gid;
    logic [7:0]  drop;
  } wr_t;

  wr_t         exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          mptr = 0;
  int          mdrop = 0;
  bit          mfreeze = 0;
  bit          mon_en = 0;
  int          edges = 0;
  logic [31:0] mbank [32] = '{default: 32'h0};
  logic [31:0] tbank [32] = '{default: 32'h0};
  bit          rv [4];
  logic [4:0]  ra [4];
  logic [31:0] rd [4];

  // Bank model driven by the DUT outputs, as the real register bank would be.
  always @(posedge CLK) begin
    for (int i = 0; i < 32; i++)
      if (WR_EN[i]) tbank[i] <= WR_DATA;
  end

  always @(posedge CLK or negedge RSTN) begin
    if (!RSTN) edges <= 0;
    else       edges <= edges + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply();
    FREEZE = mfreeze;
    for (int i = 0; i < 4; i++) begin
      REQ_VALID[i]          = rv[i];
      REQ_ADDR[i*AW +: AW]  = ra[i];
      REQ_DATA[i*DW +: DW]  = rd[i];
    end
  endtask

  // One cycle of stimulus: drive on the falling edge, predict the grant from
  // the round-robin rule, and queue the write the bank should see next cycle.
  task automatic step(output int win);
    logic [3:0] er;
    wr_t        r;
    @(negedge CLK);
    apply();
    #1;
    win = -1;
    if (RSTN && edges >= 1 && !mfreeze) begin
      for (int k = 0; k < 4; k++) begin
        int j;
        j = (mptr + k) % 4;
        if (win < 0 && rv[j]) win = j;
      end
    end
    er = (win >= 0) ? 4'(1 << win) : 4'b0;
    chk("req_ready", 32'(REQ_READY), 32'(er));
    if (win >= 0) begin
      r.en   = (ra[win] == 5'd0) ? 32'h0 : (32'h1 << ra[win]);
      r.data = rd[win];
      r.gid  = 2'(win);
      if (ra[win] == 5'd0 && mdrop < 255) mdrop++;
      r.drop = 8'(mdrop);
      exp_q.push_back(r);
      mptr = (win + 1) % 4;
    end
  endtask

  task automatic idle(input int n);
    int w;
    for (int i = 0; i < 4; i++) rv[i] = 0;
    for (int c = 0; c < n; c++) step(w);
  endtask

  // Monitor: compares the write stage against the scoreboard after each edge,
  // and commits a checked write into the model bank at the edge that captures it.
  initial begin : monitor
    wr_t pend;
    wr_t r;
    bit  have_pend;
    have_pend = 0;
    forever begin
      @(posedge CLK);
      if (have_pend && RSTN)
        for (int i = 0; i < 32; i++)
          if (pend.en[i]) mbank[i] = pend.data;
      have_pend = 0;
      #2;
      if (mon_en && RSTN) begin
        if (exp_q.size() > 0) begin
          r = exp_q.pop_front();
          chk("busy_write", 32'(BUSY), 32'd1);
          chk("wr_en", WR_EN, r.en);
          chk("wr_data", WR_DATA, r.data);
          chk("grant_id", 32'(GRANT_ID), 32'(r.gid));
          chk("drop_cnt", 32'(DROP_CNT), 32'(r.drop));
          pend = r;
          have_pend = 1;
        end else begin
          chk("busy_idle", 32'(BUSY), 32'd0);
          chk("wr_en_idle", WR_EN, 32'h0);
          chk("drop_cnt_idle", 32'(DROP_CNT), 32'(mdrop));
        end
      end
    end
  end

  initial begin : watchdog
    #300000;
    errors++;
    $display("FAIL watchdog: actual=timeout required=finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : main
    int w;
    for (int i = 0; i < 4; i++) begin
      rv[i] = 1;
      ra[i] = 5'(i + 1);
      rd[i] = $urandom;
    end
    mfreeze = 0;
    apply();
    RSTN = 0;
    repeat (3) @(negedge CLK);
    #1;
    chk("rst_ready", 32'(REQ_READY), 32'h0);
    chk("rst_wr_en", WR_EN, 32'h0);
    chk("rst_busy", 32'(BUSY), 32'h0);
    chk("rst_drop", 32'(DROP_CNT), 32'h0);
    chk("rst_gid", 32'(GRANT_ID), 32'h0);
    chk("rst_wdata", WR_DATA, 32'h0);

    // Release: no grant before the first edge, first grant to req0 on the second.
    @(negedge CLK);
    RSTN = 1;
    mon_en = 1;
    #1;
    chk("release_ready", 32'(REQ_READY), 32'h0);

    // Round robin with all requesters valid on addrs 1..4.
    for (int c = 0; c < 9; c++) step(w);
    idle(2);

    // Single write.
    rv[1] = 1; ra[1] = 5'd5; rd[1] = 32'hDEADBEEF;
    step(w);
    idle(3);

    // Register 0 drops, then a real write, then saturation.
    rv[2] = 1;
    for (int c = 0; c < 3; c++) begin
      ra[2] = 5'd0; rd[2] = $urandom;
      step(w);
    end
    ra[2] = 5'd7; rd[2] = $urandom;
    step(w);
    idle(2);
    chk("drop_three", 32'(DROP_CNT), 32'd3);
    rv[2] = 1; ra[2] = 5'd0;
    for (int c = 0; c < 260; c++) begin
      rd[2] = $urandom;
      step(w);
    end
    idle(2);
    chk("drop_saturate", 32'(DROP_CNT), 32'd255);

    // Freeze with PTR at 3: no grants, then req3 before req0.
    rv[0] = 1; ra[0] = 5'd10; rd[0] = 32'h0A0A0A0A;
    rv[3] = 1; ra[3] = 5'd11; rd[3] = 32'h0B0B0B0B;
    mfreeze = 1;
    for (int c = 0; c < 4; c++) step(w);
    mfreeze = 0;
    step(w);
    if (w == 3) rv[3] = 0;
    step(w);
    if (w == 0) rv[0] = 0;
    idle(2);

    // Two requesters to the same register: last accepted write wins.
    rv[0] = 1; ra[0] = 5'd12; rd[0] = 32'h1111_0000;
    rv[1] = 1; ra[1] = 5'd12; rd[1] = 32'h2222_0000;
    for (int c = 0; c < 2; c++) begin
      step(w);
      if (w >= 0) rv[w] = 0;
    end
    idle(2);

    // Randomized traffic with random stalls and dropped requests.
    for (int c = 0; c < 300; c++) begin
      mfreeze = ($urandom_range(0, 4) == 0);
      step(w);
      for (int i = 0; i < 4; i++) begin
        if (i == w || !rv[i]) begin
          rv[i] = ($urandom_range(0, 9) < 6);
          ra[i] = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
          rd[i] = $urandom;
        end else if ($urandom_range(0, 9) == 0) begin
          rv[i] = 0;
        end
      end
    end
    mfreeze = 0;
    idle(3);

    // Reset half a cycle after a transfer to register 9: the write is discarded.
    rv[0] = 1; ra[0] = 5'd9; rd[0] = 32'hCAFE_0009;
    step(w);
    rv[0] = 0;
    @(posedge CLK);
    @(negedge CLK);
    RSTN = 0;
    mon_en = 0;
    #1;
    chk("midrst_wr_en", WR_EN, 32'h0);
    chk("midrst_busy", 32'(BUSY), 32'h0);
    chk("midrst_drop", 32'(DROP_CNT), 32'h0);
    exp_q.delete();
    mptr = 0;
    mdrop = 0;
    repeat (2) @(negedge CLK);
    RSTN = 1;
    mon_en = 1;
    for (int i = 0; i < 4; i++) begin
      rv[i] = 1; ra[i] = 5'(20 + i); rd[i] = $urandom;
    end
    for (int c = 0; c < 6; c++) step(w);
    idle(3);

    for (int i = 0; i < 32; i++) chk($sformatf("bank%0d", i), tbank[i], mbank[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
